// File: rtl/fifo_packer_if.sv
// Handshake bundle between a byte FIFO read port, the packer, and the wide consumer.
// The master side is the packer; the slave side is the FIFO/consumer environment.
interface fifo_packer_if #(
  parameter int WIDTH   = 8,
  parameter int NUM     = 4,
  parameter int LOG_NUM = 2
);
  logic                   fifo_empty;
  logic                   fifo_re;
  logic [WIDTH-1:0]       fifo_data;
  logic                   flush;
  logic [WIDTH*NUM-1:0]   out_data;
  logic [LOG_NUM:0]       out_cnt;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    input  fifo_empty, fifo_data, flush, out_ready,
    output fifo_re, out_data, out_cnt, out_valid
  );

  modport slave (
    output fifo_empty, fifo_data, flush, out_ready,
    input  fifo_re, out_data, out_cnt, out_valid
  );
endinterface

// File: rtl/fifo_packer.sv
// Pops WIDTH-bit entries from a registered-read FIFO and packs NUM of them into one
// wide word (first pop in the LSBs); flush emits a zero-padded partial word.
module fifo_packer #(
  parameter int WIDTH   = 8,
  parameter int NUM     = 4,
  parameter int LOG_NUM = 2
) (
  input  logic          clk,
  input  logic          rst,
  fifo_packer_if.master bus
);

  typedef enum logic {FILL, OUT} state_t;

  localparam logic [LOG_NUM:0] NUM_W = (LOG_NUM+1)'(NUM);
  localparam logic [LOG_NUM:0] ONE_W = (LOG_NUM+1)'(1);

  state_t           state, state_n;
  logic [LOG_NUM:0] idx, idx_n;
  logic [LOG_NUM:0] cnt, cnt_n;
  logic             rd_pend;
  logic             flush_pend, flush_pend_n;
  logic             re;
  logic [WIDTH-1:0] lanes   [NUM];
  logic [WIDTH-1:0] lanes_n [NUM];

  // Count the pop still in flight so we never request more entries than lanes remain.
  always_comb begin
    re = !rst && (state == FILL) && !bus.fifo_empty && !flush_pend &&
         ((idx + (LOG_NUM+1)'(rd_pend)) < NUM_W);
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    flush_pend_n = flush_pend | bus.flush;
    lanes_n      = lanes;
    unique case (state)
      FILL: begin
        if (rd_pend) begin
          lanes_n[idx[LOG_NUM-1:0]] = bus.fifo_data;
          idx_n = idx + ONE_W;
          if (idx_n == NUM_W) begin
            state_n = OUT;
            cnt_n   = NUM_W;
          end
        end else if (flush_pend) begin
          if (idx != '0) begin
            state_n = OUT;
            cnt_n   = idx;
          end else begin
            flush_pend_n = bus.flush;
          end
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_n      = FILL;
          idx_n        = '0;
          cnt_n        = '0;
          flush_pend_n = 1'b0;
          for (int unsigned k = 0; k < NUM; k++) lanes_n[k] = '0;
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      idx        <= '0;
      cnt        <= '0;
      rd_pend    <= 1'b0;
      flush_pend <= 1'b0;
      for (int unsigned k = 0; k < NUM; k++) lanes[k] <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      rd_pend    <= re;
      flush_pend <= flush_pend_n;
      lanes      <= lanes_n;
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int unsigned k = 0; k < NUM; k++) bus.out_data[k*WIDTH +: WIDTH] = lanes[k];
  end

  assign bus.fifo_re   = re;
  assign bus.out_valid = (state == OUT);
  assign bus.out_cnt   = cnt;

endmodule

// File: tb/tb_fifo_packer.sv
// Directed bench for fifo_packer: a FIFO model feeds bytes, expected words go into a
// scoreboard at stimulus time and are checked when the output handshake completes.
module tb_fifo_packer;
  localparam int WIDTH   = 8;
  localparam int NUM     = 4;
  localparam int LOG_NUM = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_packer_if #(.WIDTH(WIDTH), .NUM(NUM), .LOG_NUM(LOG_NUM)) bus ();

  fifo_packer #(.WIDTH(WIDTH), .NUM(NUM), .LOG_NUM(LOG_NUM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // FIFO model: registered read, one-cycle latency
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign bus.fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (bus.fifo_re) begin
      bus.fifo_data <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 8'd1;
    end
  end

  int n_asserts = 0;
  int n_fail    = 0;
  int n_words   = 0;
  logic [31:0] exp_data_q [$];
  logic [2:0]  exp_cnt_q  [$];
  bit          hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic [2:0]  hold_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [2:0] c);
    exp_data_q.push_back(d);
    exp_cnt_q.push_back(c);
  endtask

  // Values sampled here are the ones the next rising edge will act on.
  task automatic monitor();
    if (bus.fifo_re) chk("no_underflow", bus.fifo_empty, 0);
    if (bus.out_valid) chk("no_pop_in_out", bus.fifo_re, 0);
    if (hold_pend) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, hold_data);
      chk("hold_cnt", bus.out_cnt, hold_cnt);
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_words++;
      n_asserts++;
      assert (exp_data_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_word observed=%0h/%0d expected=none", bus.out_data, bus.out_cnt);
      end
      if (exp_data_q.size() != 0) begin
        chk("word_data", bus.out_data, exp_data_q.pop_front());
        chk("word_cnt", bus.out_cnt, exp_cnt_q.pop_front());
      end
    end
    hold_pend = !rst && bus.out_valid && !bus.out_ready;
    hold_data = bus.out_data;
    hold_cnt  = bus.out_cnt;
  endtask

  task automatic tick();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      if (exp_data_q.size() == 0 && rd_ptr == wr_ptr && !bus.out_valid) done = 1'b1;
      else tick();
    end
    chk("wait_idle", done, 1);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  initial begin
    int n_re, n_v, first_re, first_v, n_held, w;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_cnt", bus.out_cnt, 0);
    chk("rst_fifo_re", bus.fifo_re, 0);
    rst = 1'b0;

    // Fill one word, measure pop count and latency
    bus.out_ready = 1'b1;
    push(8'h10); push(8'h32); push(8'h54); push(8'h76);
    expect_word(32'h76543210, 3'd4);
    n_re = 0; n_v = 0; first_re = -1; first_v = -1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus.fifo_re) begin n_re++; if (first_re < 0) first_re = i; end
      if (bus.out_valid) begin n_v++; if (first_v < 0) first_v = i; end
      tick();
    end
    chk("fill_re_cycles", n_re, 4);
    chk("fill_latency", first_v - first_re, 5);
    chk("fill_valid_cycles", n_v, 1);

    // Backpressure across two words
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i));
    expect_word(32'h03020100, 3'd4);
    expect_word(32'h07060504, 3'd4);
    n_held = 0;
    repeat (16) begin
      #1;
      if (bus.out_valid) n_held++;
      tick();
    end
    chk("bp_held_cycles", n_held, 11);
    bus.out_ready = 1'b1;
    wait_idle(40);

    // Partial flush, then a flush with nothing buffered
    push(8'hAA); push(8'hBB);
    expect_word(32'h0000BBAA, 3'd2);
    repeat (4) tick();
    pulse_flush();
    wait_idle(20);
    w = n_words;
    pulse_flush();
    repeat (10) tick();
    chk("empty_flush_no_word", n_words, w);

    // FIFO runs dry mid-word
    w = n_words;
    push(8'h11);
    expect_word(32'h44332211, 3'd4);
    tick(); tick();
    n_re = 0;
    repeat (20) begin
      #1;
      if (bus.fifo_re) n_re++;
      tick();
    end
    chk("stall_no_re", n_re, 0);
    chk("stall_no_word", n_words, w);
    push(8'h22); push(8'h33); push(8'h44);
    wait_idle(20);

    // Flush on the cycle of the 4th capture
    w = n_words;
    push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
    expect_word(32'hC3C2C1C0, 3'd4);
    repeat (4) tick();
    pulse_flush();
    repeat (12) tick();
    wait_idle(20);
    chk("coinc_flush_one_word", n_words, w + 1);

    // Reset with three lanes filled and a pop in flight
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    repeat (4) tick();
    rst = 1'b1;
    push(8'h61); push(8'h62);
    tick();
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_out_cnt", bus.out_cnt, 0);
    chk("midrst_fifo_re", bus.fifo_re, 0);
    tick();
    rst = 1'b0;
    expect_word(32'h00006261, 3'd2);
    repeat (4) tick();
    pulse_flush();
    wait_idle(20);
    push(8'h71); push(8'h72); push(8'h73); push(8'h74);
    expect_word(32'h74737271, 3'd4);
    wait_idle(20);

    chk("scoreboard_drained", exp_data_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
